// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding, default
// word width and the bit-counter width helper.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Counter must hold values up to WIDTH (frame length minus one, with parity).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with enable, asynchronous active-high reset and a
// zero flag. The serializer uses it to track the remaining bits of a frame.
module bit_down_counter #(
    parameter int CW = 6
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] value_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: load wins over decrement, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i) begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == {CW{1'b0}});

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, serial-out reader for register words. A word captured on
// ctrl_load is shifted out one bit per accepted valid/ready transfer.
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity bit
// to every frame.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_load,
    input  logic [WIDTH-1:0] in,
    input  logic             ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    ser_state_e       state_q, state_d;
    logic [FRAME-1:0] sr_q, sr_d;
    logic [FRAME-1:0] load_frame_s;
    logic [FRAME-1:0] shifted_s;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer_s;
    logic             cnt_load_s;
    logic             cnt_en_s;
    logic [CW-1:0]    cnt_s;
    logic             cnt_zero_s;

`ifdef SERIALIZER_PARITY_EN
    // Even parity over the data bits of one word.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        even_parity = ^w;
    endfunction
`endif

    // The bit presented on the link is at the output end of the register.
    function automatic logic head_bit(input logic [FRAME-1:0] v);
        if (MSB_FIRST) begin
            head_bit = v[FRAME-1];
        end else begin
            head_bit = v[0];
        end
    endfunction

    // Frame image at load time and one-position shift toward the output end.
    always_comb begin
`ifdef SERIALIZER_PARITY_EN
        if (MSB_FIRST) begin
            load_frame_s = {in, even_parity(in)};
        end else begin
            load_frame_s = {even_parity(in), in};
        end
`else
        load_frame_s = in;
`endif
        if (MSB_FIRST) begin
            shifted_s = {sr_q[FRAME-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, sr_q[FRAME-1:1]};
        end
    end

    bit_down_counter #(
        .CW (CW)
    ) u_cnt (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .load_i     (cnt_load_s),
        .en_i       (cnt_en_s),
        .value_i    (LAST_IDX),
        .count_o    (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // FSM next state, shift register update and next values of the output registers.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        xfer_s     = (state_q == SHIFT) && ready;

        case (state_q)
            IDLE: begin
                if (ctrl_load) begin
                    state_d    = SHIFT;
                    sr_d       = load_frame_s;
                    cnt_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s) begin
                    sr_d     = shifted_s;
                    // The final transfer leaves the counter at zero instead of wrapping.
                    cnt_en_s = !cnt_zero_s;
                    if (cnt_zero_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bit_valid_d = (state_d == SHIFT);
        busy_d      = (state_d == SHIFT);
        done_d      = xfer_s && cnt_zero_s;
        if (state_d == SHIFT) begin
            bit_out_d = head_bit(sr_d);
        end else begin
            bit_out_d = 1'b0;
        end

        // last mirrors "counter will be zero" so it can come straight from a flop.
        if (state_d != SHIFT) begin
            last_d = 1'b0;
        end else if (cnt_load_s) begin
            last_d = (LAST_IDX == {CW{1'b0}});
        end else if (cnt_en_s) begin
            last_d = (cnt_s == CNT_ONE);
        end else begin
            last_d = last_q;
        end
    end

    // State, shift register and registered outputs.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q     <= IDLE;
            sr_q        <= {FRAME{1'b0}};
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one MSB-first and one LSB-first
// instance share all inputs and are checked cycle by cycle.
module tb_word_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = 33;
`else
    localparam int FRAME = 32;
`endif

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_load;
    logic [31:0] in_s;
    logic        ready;
    logic        m_bit, m_valid, m_last, m_busy, m_done;
    logic        l_bit, l_valid, l_last, l_busy, l_done;
    logic        hold_load;
    int          checks;
    int          errors;

    word_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clock (clock), .ctrl_reset (ctrl_reset), .ctrl_load (ctrl_load),
        .in (in_s), .ready (ready), .bit_out (m_bit), .bit_valid (m_valid),
        .last (m_last), .busy (m_busy), .done (m_done)
    );

    word_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clock (clock), .ctrl_reset (ctrl_reset), .ctrl_load (ctrl_load),
        .in (in_s), .ready (ready), .bit_out (l_bit), .bit_valid (l_valid),
        .last (l_last), .busy (l_busy), .done (l_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected frame bit n of word w (bit 32 is the even-parity bit).
    function automatic logic fbit(input logic [31:0] w, input int n, input bit msb);
        if (n >= 32) return ^w;
        return msb ? w[31-n] : w[n];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_m_bit"},   m_bit,   1'b0);
        chk({tag, "_l_bit"},   l_bit,   1'b0);
        chk({tag, "_valid"},   m_valid, 1'b0);
        chk({tag, "_l_valid"}, l_valid, 1'b0);
        chk({tag, "_last"},    m_last,  1'b0);
        chk({tag, "_busy"},    m_busy,  1'b0);
        chk({tag, "_l_busy"},  l_busy,  1'b0);
    endtask

    task automatic chk_bit(input int n, input logic [31:0] w);
        chk($sformatf("m_bit%0d", n), m_bit, fbit(w, n, 1'b1));
        chk($sformatf("l_bit%0d", n), l_bit, fbit(w, n, 1'b0));
        chk($sformatf("valid%0d", n), m_valid & l_valid, 1'b1);
        chk($sformatf("last%0d", n), m_last, (n == FRAME - 1));
        chk($sformatf("l_last%0d", n), l_last, (n == FRAME - 1));
        chk($sformatf("busy%0d", n), m_busy & l_busy, 1'b1);
        chk($sformatf("done%0d", n), m_done | l_done, 1'b0);
    endtask

    // Called in the cycle after the load edge; returns in the done cycle.
    task automatic check_frame(input logic [31:0] w, input int stall_n, input int stall_len,
                               input int poke_n, input logic [31:0] poke_w);
        for (int n = 0; n < FRAME; n++) begin
            chk_bit(n, w);
            if (n == stall_n) begin
                ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk_bit(n, w);
                end
                ready = 1'b1;
            end
            if (n == poke_n) begin
                ctrl_load = 1'b1;
                in_s      = poke_w;
            end
            step();
            ctrl_load = hold_load;
        end
        chk("done_m", m_done, 1'b1);
        chk("done_l", l_done, 1'b1);
        chk_idle("donecyc");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        hold_load  = 1'b0;
        ctrl_reset = 1'b1;
        ctrl_load  = 1'b0;
        in_s       = 32'h0000_0000;
        ready      = 1'b1;
        step();
        chk_idle("reset");
        chk("reset_done", m_done | l_done, 1'b0);
        ctrl_reset = 1'b0;
        step();
        chk_idle("post_reset");

        // Single-one-at-each-end word, no backpressure.
        ctrl_load = 1'b1;
        in_s      = 32'h8000_0001;
        step();
        ctrl_load = 1'b0;
        check_frame(32'h8000_0001, -1, 0, -1, 32'h0);
        step();
        chk("done_pulse_once", m_done | l_done, 1'b0);
        chk_idle("after1");

        // Backpressure: ready low for 3 cycles after two transfers.
        ctrl_load = 1'b1;
        in_s      = 32'h0000_000F;
        step();
        ctrl_load = 1'b0;
        check_frame(32'h0000_000F, 2, 3, -1, 32'h0);
        step();

        // Load during SHIFT is ignored.
        ctrl_load = 1'b1;
        in_s      = 32'hAAAA_AAAA;
        step();
        ctrl_load = 1'b0;
        check_frame(32'hAAAA_AAAA, -1, 0, 10, 32'h5555_5555);
        step();
        chk("no_second_done", m_done | l_done, 1'b0);
        chk_idle("after_poke");

        // Asynchronous reset in the middle of bit 17.
        ctrl_load = 1'b1;
        in_s      = 32'hFFFF_FFFF;
        step();
        ctrl_load = 1'b0;
        for (int n = 0; n < 17; n++) step();
        chk_bit(17, 32'hFFFF_FFFF);
        #2;
        ctrl_reset = 1'b1;
        #1;
        chk_idle("async_reset");
        chk("async_reset_done", m_done | l_done, 1'b0);
        step();
        ctrl_reset = 1'b0;
        step();
        chk_idle("post_abort");
        chk("post_abort_done", m_done | l_done, 1'b0);
        ctrl_load = 1'b1;
        in_s      = 32'h1234_5678;
        step();
        ctrl_load = 1'b0;
        check_frame(32'h1234_5678, -1, 0, -1, 32'h0);
        step();

`ifdef SERIALIZER_PARITY_EN
        // Parity bit: 0x7 has odd weight, 0x3 even weight.
        ctrl_load = 1'b1;
        in_s      = 32'h0000_0007;
        step();
        ctrl_load = 1'b0;
        for (int n = 0; n < 32; n++) step();
        chk("par7_m", m_bit, 1'b1);
        chk("par7_l", l_bit, 1'b1);
        chk("par7_last", m_last & l_last, 1'b1);
        step();
        chk("par7_done", m_done, 1'b1);
        step();
        ctrl_load = 1'b1;
        in_s      = 32'h0000_0003;
        step();
        ctrl_load = 1'b0;
        check_frame(32'h0000_0003, -1, 0, -1, 32'h0);
        step();
`endif

        // Continuous load request: back-to-back frames with a one-cycle bubble.
        hold_load = 1'b1;
        ctrl_load = 1'b1;
        in_s      = 32'hC3A5_0F96;
        step();
        check_frame(32'hC3A5_0F96, -1, 0, -1, 32'h0);
        in_s = 32'h0123_4567;
        step();
        check_frame(32'h0123_4567, -1, 0, -1, 32'h0);
        hold_load = 1'b0;
        ctrl_load = 1'b0;
        step();
        chk_idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
